// File: rtl/axil_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module : axil_dmem_pkg
// Brief  : Shared response codes, strobe width and address-map helpers for
//          the AXI4-Lite data-memory slave.
// Rev    : 1.0
// ============================================================================
package axil_dmem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int AXIL_DATA_WIDTH = 32;
    localparam int STRB_WIDTH      = AXIL_DATA_WIDTH / 8;

    // Operands are widened to 64 bits so the offset can never wrap for any
    // address width up to 64.
    function automatic logic addr_in_range(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] depth_words
    );
        logic [63:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 2) < depth_words);
    endfunction

    function automatic logic [63:0] word_index(
        input logic [63:0] addr,
        input logic [63:0] base
    );
        return (addr - base) >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_dmem_if.sv
`default_nettype none
// ============================================================================
// Module : axil_dmem_if
// Brief  : AXI4-Lite bus bundle (AW/W/B/AR/R) with master/slave modports.
// Rev    : 1.0
// ============================================================================
interface axil_dmem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bram.sv
`default_nettype none
// ============================================================================
// Module : dmem_bram
// Brief  : Single-clock byte-enabled RAM, synchronous read-before-write.
// Rev    : 1.0
// ============================================================================
module dmem_bram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  wire logic                    clk_i,
    input  wire logic                    we_i,
    input  wire logic [DATA_WIDTH/8-1:0] be_i,
    input  wire logic [IDX_W-1:0]        waddr_i,
    input  wire logic [DATA_WIDTH-1:0]   wdata_i,
    input  wire logic                    re_i,
    input  wire logic [IDX_W-1:0]        raddr_i,
    output logic      [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    // Read and write share one block so a same-address collision returns
    // the pre-write contents, which is the mode block RAM offers natively.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
        if (we_i) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module : axil_dmem_slave
// Brief  : AXI4-Lite responder data memory; OKAY in range, SLVERR outside.
// Rev    : 1.0
// ============================================================================
module axil_dmem_slave
    import axil_dmem_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input wire logic   aclk,
    input wire logic   aresetn,
    axil_dmem_if.slave s
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic                  w_full_q,  w_full_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic                  rvalid_q,  rvalid_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic                  rhit_q,    rhit_d;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic                  w_aw_hit, w_ar_hit;
    logic [IDX_W-1:0]      w_aw_idx, w_ar_idx;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // Readies are gated by aresetn so nothing is accepted during reset.
    assign s.awready = aresetn & ~aw_full_q & ~bvalid_q;
    assign s.wready  = aresetn & ~w_full_q  & ~bvalid_q;
    assign s.arready = aresetn & (~rvalid_q | s.rready);

    assign w_aw_hs  = s.awvalid & s.awready;
    assign w_w_hs   = s.wvalid  & s.wready;
    assign w_ar_hs  = s.arvalid & s.arready;
    assign w_commit = aw_full_q & w_full_q & ~bvalid_q;

    assign w_aw_hit = addr_in_range(64'(awaddr_q), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
    assign w_ar_hit = addr_in_range(64'(s.araddr), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
    assign w_aw_idx = IDX_W'(word_index(64'(awaddr_q), 64'(BASE_ADDR)));
    assign w_ar_idx = IDX_W'(word_index(64'(s.araddr), 64'(BASE_ADDR)));

    always_comb begin
        aw_full_d = aw_full_q;
        awaddr_d  = awaddr_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rhit_d    = rhit_q;

        if (w_aw_hs) begin
            aw_full_d = 1'b1;
            awaddr_d  = s.awaddr;
        end
        if (w_w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = s.wdata;
            wstrb_d  = s.wstrb;
        end
        if (w_commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_aw_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s.bready) begin
            bvalid_d = 1'b0;
        end

        if (w_ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = w_ar_hit ? RESP_OKAY : RESP_SLVERR;
            rhit_d   = w_ar_hit;
        end else if (s.rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full_q <= 1'b0;
            awaddr_q  <= '0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rhit_q    <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            awaddr_q  <= awaddr_d;
            w_full_q  <= w_full_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rhit_q    <= rhit_d;
        end
    end

    dmem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_bram (
        .clk_i   (aclk),
        .we_i    (w_commit & w_aw_hit),
        .be_i    (wstrb_q),
        .waddr_i (w_aw_idx),
        .wdata_i (wdata_q),
        .re_i    (w_ar_hs & w_ar_hit),
        .raddr_i (w_ar_idx),
        .rdata_o (w_ram_rdata)
    );

    // The RAM output is not reset; masking it keeps rdata at zero after reset
    // and for out-of-range reads.
    assign s.rdata  = rhit_q ? w_ram_rdata : '0;
    assign s.rresp  = rresp_q;
    assign s.rvalid = rvalid_q;
    assign s.bresp  = bresp_q;
    assign s.bvalid = bvalid_q;

endmodule
`default_nettype wire
